// File: rtl/status_pkg.sv
// Shared status-flag definitions: flag bit positions, default width and the
// stack operation encoding used between the flag register and its save stack.
package status_pkg;

   localparam int STATUS_W = 4;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_PUSH = 2'd1,
      OP_POP  = 2'd2,
      OP_SWAP = 2'd3
   } stack_op_e;

endpackage

// File: rtl/flag_lifo.sv
// Register-array LIFO holding saved flag frames. The caller guarantees that at
// most one of push_en/pop_en/swap_en is set and that each is legal for the depth.
module flag_lifo
   import status_pkg::*;
#(
   parameter int WIDTH = STATUS_W,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_en,
   input  logic                       pop_en,
   input  logic                       swap_en,
   input  logic [WIDTH-1:0]           wr_data,
   output logic [WIDTH-1:0]           top_data,
   output logic [$clog2(DEPTH+1)-1:0] depth,
   output logic                       full,
   output logic                       empty
);

   localparam int DW = $clog2(DEPTH+1);

   logic [DW-1:0]    depth_q, depth_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   always_comb begin
      depth_d = depth_q;
      mem_d   = mem_q;
      if (push_en) begin
         depth_d = depth_q + 1'b1;
      end else if (pop_en) begin
         depth_d = depth_q - 1'b1;
      end
      // push writes the slot just above the top; swap overwrites the top itself
      for (int i = 0; i < DEPTH; i++) begin
         if ((push_en && depth_q == DW'(i)) || (swap_en && depth_q == DW'(i + 1))) begin
            mem_d[i] = wr_data;
         end
      end
   end

   always_comb begin
      top_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (depth_q == DW'(i + 1)) begin
            top_data = mem_q[i];
         end
      end
   end

   always_ff @(negedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         depth_q <= '0;
      end else begin
         depth_q <= depth_d;
      end
   end

   assign depth = depth_q;
   assign full  = (depth_q == DW'(DEPTH));
   assign empty = (depth_q == '0);

endmodule

// File: rtl/status_register_stack.sv
// Processor status register with per-bit masked load and a LIFO of saved flag
// frames for nested exception entry/return. All state updates on the falling edge.
module status_register_stack
   import status_pkg::*;
#(
   parameter int               WIDTH       = STATUS_W,
   parameter int               DEPTH       = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ld,
   input  logic [WIDTH-1:0]           flag_mask,
   input  logic [WIDTH-1:0]           flags_in,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       clr_err,
   output logic [WIDTH-1:0]           flags,
   output logic [$clog2(DEPTH+1)-1:0] depth,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow_err,
   output logic                       underflow_err
);

   logic [WIDTH-1:0] flags_q, flags_d;
   logic             ovf_err_q, ovf_err_d;
   logic             unf_err_q, unf_err_d;

   logic [WIDTH-1:0] ld_val;
   logic [WIDTH-1:0] top_data;
   logic             stk_full, stk_empty;
   logic             ovf_set, unf_set;
   stack_op_e        op;

   assign ld_val = (flags_q & ~flag_mask) | (flags_in & flag_mask);

   always_comb begin
      op      = OP_NONE;
      flags_d = flags_q;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      // A successful restore (pop or swap) owns the flag register; ld is dropped.
      if (push && pop && !stk_empty) begin
         op      = OP_SWAP;
         flags_d = top_data;
      end else if (pop && !push) begin
         if (!stk_empty) begin
            op      = OP_POP;
            flags_d = top_data;
         end else begin
            unf_set = 1'b1;
            if (ld) flags_d = ld_val;
         end
      end else begin
         if (push) begin
            if (!stk_full) op = OP_PUSH;
            else           ovf_set = 1'b1;
         end
         if (ld) flags_d = ld_val;
      end
      ovf_err_d = ovf_set | (ovf_err_q & ~clr_err);
      unf_err_d = unf_set | (unf_err_q & ~clr_err);
   end

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         flags_q   <= RESET_VALUE;
         ovf_err_q <= 1'b0;
         unf_err_q <= 1'b0;
      end else begin
         flags_q   <= flags_d;
         ovf_err_q <= ovf_err_d;
         unf_err_q <= unf_err_d;
      end
   end

   flag_lifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_lifo (
      .clk      (clk),
      .rst      (rst),
      .push_en  (op == OP_PUSH),
      .pop_en   (op == OP_POP),
      .swap_en  (op == OP_SWAP),
      .wr_data  (flags_q),
      .top_data (top_data),
      .depth    (depth),
      .full     (stk_full),
      .empty    (stk_empty)
   );

   assign flags         = flags_q;
   assign full          = stk_full;
   assign empty         = stk_empty;
   assign overflow_err  = ovf_err_q;
   assign underflow_err = unf_err_q;

endmodule

// File: tb/tb_status_register_stack.sv
// Bench for status_register_stack: directed scenarios with literal expectations
// followed by randomized traffic checked every cycle against a queue-based model.
module tb_status_register_stack;
   import status_pkg::*;

   localparam int WIDTH = STATUS_W;
   localparam int DEPTH = 4;
   localparam int DW    = $clog2(DEPTH+1);

   logic             clk;
   logic             rst;
   logic             ld;
   logic [WIDTH-1:0] flag_mask;
   logic [WIDTH-1:0] flags_in;
   logic             push;
   logic             pop;
   logic             clr_err;
   logic [WIDTH-1:0] flags;
   logic [DW-1:0]    depth;
   logic             full;
   logic             empty;
   logic             overflow_err;
   logic             underflow_err;

   status_register_stack #(
      .WIDTH       (WIDTH),
      .DEPTH       (DEPTH),
      .RESET_VALUE ('0)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ld            (ld),
      .flag_mask     (flag_mask),
      .flags_in      (flags_in),
      .push          (push),
      .pop           (pop),
      .clr_err       (clr_err),
      .flags         (flags),
      .depth         (depth),
      .full          (full),
      .empty         (empty),
      .overflow_err  (overflow_err),
      .underflow_err (underflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   // behavioural model: flag value, a queue as the save stack, two sticky bits
   logic [WIDTH-1:0] m_flags;
   logic [WIDTH-1:0] m_stack[$];
   bit               m_ov;
   bit               m_uf;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_flags = '0;
      m_stack.delete();
      m_ov = 1'b0;
      m_uf = 1'b0;
   endtask

   task automatic model_step();
      logic [WIDTH-1:0] loaded;
      logic [WIDTH-1:0] tmp;
      bit               ov_ev;
      bit               uf_ev;
      loaded = ld ? ((m_flags & ~flag_mask) | (flags_in & flag_mask)) : m_flags;
      ov_ev  = 1'b0;
      uf_ev  = 1'b0;
      if (push && pop && m_stack.size() > 0) begin
         tmp = m_stack[m_stack.size()-1];
         m_stack[m_stack.size()-1] = m_flags;
         m_flags = tmp;
      end else if (pop && !push) begin
         if (m_stack.size() > 0) m_flags = m_stack.pop_back();
         else begin
            uf_ev   = 1'b1;
            m_flags = loaded;
         end
      end else begin
         if (push) begin
            if (m_stack.size() < DEPTH) m_stack.push_back(m_flags);
            else ov_ev = 1'b1;
         end
         m_flags = loaded;
      end
      m_ov = ov_ev || (m_ov && !clr_err);
      m_uf = uf_ev || (m_uf && !clr_err);
   endtask

   always @(negedge clk) begin
      if (!rst) model_step();
   end

   always @(posedge clk) begin
      if (cmp_en && !rst) begin
         chk("cyc_flags", int'(flags), int'(m_flags));
         chk("cyc_depth", int'(depth), m_stack.size());
         chk("cyc_full",  int'(full),  int'(m_stack.size() == DEPTH));
         chk("cyc_empty", int'(empty), int'(m_stack.size() == 0));
         chk("cyc_ovf",   int'(overflow_err),  int'(m_ov));
         chk("cyc_unf",   int'(underflow_err), int'(m_uf));
      end
   end

   task automatic idle();
      ld = 1'b0; flag_mask = '0; flags_in = '0;
      push = 1'b0; pop = 1'b0; clr_err = 1'b0;
   endtask

   // one transaction sampled at the next falling edge; inputs return to idle after it
   task automatic op(input logic l, input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] fi,
                     input logic pu, input logic po, input logic cl);
      @(posedge clk);
      #1;
      ld = l; flag_mask = m; flags_in = fi; push = pu; pop = po; clr_err = cl;
      @(negedge clk);
      #1;
      idle();
   endtask

   task automatic reset_pulse_check(input string tag);
      @(posedge clk);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk({tag, "_flags"}, int'(flags), 0);
      chk({tag, "_depth"}, int'(depth), 0);
      chk({tag, "_empty"}, int'(empty), 1);
      chk({tag, "_full"},  int'(full),  0);
      chk({tag, "_ovf"},   int'(overflow_err),  0);
      chk({tag, "_unf"},   int'(underflow_err), 0);
      rst = 1'b0;
   endtask

   logic [WIDTH-1:0] vals [4];

   initial begin
      idle();
      rst = 1'b1;
      model_reset();
      #3;
      chk("rst_flags", int'(flags), 0);
      chk("rst_empty", int'(empty), 1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cmp_en = 1'b1;

      // masked load, then an all-zero mask holds
      op(1'b1, 4'b1010, 4'b1111, 1'b0, 1'b0, 1'b0);
      chk("t2_ld_masked", int'(flags), 4'b1010);
      op(1'b1, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
      chk("t2_mask0_hold", int'(flags), 4'b1010);

      // save, overwrite, restore
      op(1'b1, 4'hF, 4'b0101, 1'b0, 1'b0, 1'b0);
      op(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
      chk("t3_push_depth", int'(depth), 1);
      op(1'b1, 4'hF, 4'b1000, 1'b0, 1'b0, 1'b0);
      chk("t3_ld_flags", int'(flags), 4'b1000);
      chk("t3_ld_depth", int'(depth), 1);
      op(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      chk("t3_pop_flags", int'(flags), 4'b0101);
      chk("t3_pop_depth", int'(depth), 0);
      chk("t3_pop_empty", int'(empty), 1);

      // fill, overflow, drain in reverse order, underflow
      vals[0] = 4'h3; vals[1] = 4'h6; vals[2] = 4'h9; vals[3] = 4'hC;
      for (int i = 0; i < 4; i++) begin
         op(1'b1, 4'hF, vals[i], 1'b0, 1'b0, 1'b0);
         op(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
      end
      chk("t4_full", int'(full), 1);
      op(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
      chk("t4_ovf", int'(overflow_err), 1);
      chk("t4_ovf_depth", int'(depth), 4);
      op(1'b1, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 3; i >= 0; i--) begin
         op(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
         chk("t4_pop_val", int'(flags), int'(vals[i]));
      end
      op(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      chk("t4_unf", int'(underflow_err), 1);
      chk("t4_unf_flags", int'(flags), 4'h3);
      chk("t4_unf_depth", int'(depth), 0);
      op(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
      chk("t4_clr_ovf", int'(overflow_err), 0);
      chk("t4_clr_unf", int'(underflow_err), 0);

      // swap: push+pop+ld with one saved frame
      op(1'b1, 4'hF, 4'b0011, 1'b0, 1'b0, 1'b0);
      op(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
      op(1'b1, 4'hF, 4'b1100, 1'b0, 1'b0, 1'b0);
      op(1'b1, 4'hF, 4'b1111, 1'b1, 1'b1, 1'b0);
      chk("t5_swap_flags", int'(flags), 4'b0011);
      chk("t5_swap_depth", int'(depth), 1);
      op(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      chk("t5_swap_top", int'(flags), 4'b1100);

      // push+pop on empty behaves as push with ld honoured
      op(1'b1, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0);
      chk("empty_pp_flags", int'(flags), 4'b1101);
      chk("empty_pp_depth", int'(depth), 1);
      chk("empty_pp_unf", int'(underflow_err), 0);

      // error set wins over a coincident clear
      for (int i = 0; i < 3; i++) op(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
      op(1'b1, 4'b1 << FLAG_Z, 4'hF, 1'b1, 1'b0, 1'b1);
      chk("t6_set_wins", int'(overflow_err), 1);
      chk("t6_ld_when_full", int'(flags), 4'b1101 | (1 << FLAG_Z));
      op(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
      chk("t6_clr", int'(overflow_err), 0);

      // asynchronous reset mid-nesting
      op(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
      reset_pulse_check("t1");

      op(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      op(1'b1, (4'b1 << FLAG_N) | (4'b1 << FLAG_V), 4'hF, 1'b0, 1'b1, 1'b1);
      chk("unf_set_wins", int'(underflow_err), 1);
      chk("unf_ld_honoured", int'(flags), 4'b1001);
      op(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
      chk("unf_clr", int'(underflow_err), 0);
      chk("flag_c_clear", int'(flags[FLAG_C]), 0);

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk);
         #1;
         ld        = ($urandom_range(0, 99) < 50);
         flag_mask = WIDTH'($urandom);
         flags_in  = WIDTH'($urandom);
         push      = ($urandom_range(0, 99) < 40);
         pop       = ($urandom_range(0, 99) < 35);
         clr_err   = ($urandom_range(0, 99) < 8);
         if ($urandom_range(0, 199) == 0) begin
            #1;
            rst = 1'b1;
            model_reset();
            #1;
            chk("rnd_rst_flags", int'(flags), 0);
            chk("rnd_rst_depth", int'(depth), 0);
            rst = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      idle();
      repeat (2) @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
